// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU bus interface: control opcodes,
// state encodings and status/register bit positions.
package vdp_pkg;

  // Second control byte, bits [7:6]
  localparam logic [1:0] CTL_REG   = 2'b10;
  localparam logic [1:0] CTL_WADDR = 2'b01;
  localparam logic [1:0] CTL_RADDR = 2'b00;

  localparam int STATUS_F_BIT = 7;
  localparam int REG1_IE_BIT  = 5;

  typedef enum logic {
    FIRST,
    SECOND
  } ctl_state_e;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LATCH
  } pf_state_e;

  // Status byte as seen on a control-port read
  function automatic logic [7:0] status_byte(input logic frame_flag);
    logic [7:0] s;
    s = 8'h00;
    s[STATUS_F_BIT] = frame_flag;
    return s;
  endfunction

endpackage

// File: rtl/vdp_prefetch.sv
// VRAM read-ahead: fetches the byte at the pointer into the read buffer so
// the next CPU data read can be answered without waiting on VRAM.
//
// state | meaning
// IDLE  | no read in flight, buffer holds last fetched/written byte
// FETCH | vram_re high, VRAM samples the address at the end of this cycle
// LATCH | vram_rdata valid, captured into the buffer at the end of this cycle
//
// A CPU data write (wr) kills any read in flight: the written byte goes into
// the buffer and the late vram_rdata is dropped. Reset abandons a read too.
module vdp_prefetch
  import vdp_pkg::*;
(
  input  logic       phi,
  input  logic       reset,
  input  logic       start,
  input  logic       wr,
  input  logic [7:0] wdata,
  input  logic [7:0] rdata,
  output logic [7:0] buffer,
  output logic       re
);

  pf_state_e pf_state;

  // Prefetch sequencing, buffer capture and write abort
  always_ff @(negedge phi) begin
    if (reset) begin
      pf_state <= IDLE;
      re       <= 1'b0;
      buffer   <= 8'h00;
    end else begin
      re <= 1'b0;
      if (wr) begin
        pf_state <= IDLE;
        buffer   <= wdata;
      end else if (start) begin
        pf_state <= FETCH;
        re       <= 1'b1;
      end else begin
        case (pf_state)
          FETCH: pf_state <= LATCH;
          LATCH: begin
            buffer   <= rdata;
            pf_state <= IDLE;
          end
          default: pf_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/vdp_bus_if.sv
// Z180 I/O port interface to the VDP: data/control port decode, two-byte
// control protocol, auto-incrementing VRAM pointer, status with frame flag
// and maskable frame interrupt. All state moves on the falling edge of phi.
//
// state  | meaning
// FIRST  | next control write is the first byte, latched
// SECOND | next control write is a command using the latched byte
module vdp_bus_if
  import vdp_pkg::*;
#(
  parameter logic [7:0] PORT_BASE = 8'h80,
  parameter int         ADDR_W    = 14,
  parameter int         NUM_REGS  = 8
) (
  input  logic                    phi,
  input  logic                    reset,
  input  logic [7:0]              a,
  input  logic [7:0]              d_in,
  input  logic                    iorq_rd,
  input  logic                    rd_tick,
  input  logic                    wr_tick,
  output logic [7:0]              d_out,
  output logic                    d_oe,
  output logic [ADDR_W-1:0]       vram_addr,
  output logic [7:0]              vram_wdata,
  output logic                    vram_we,
  output logic                    vram_re,
  input  logic [7:0]              vram_rdata,
  input  logic                    frame_tick,
  output logic [8*NUM_REGS-1:0]   regs,
  output logic                    int_n
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic              hit_data;
  logic              hit_ctl;
  logic              wr_data;
  logic              wr_ctl;
  logic              rd_data;
  logic              rd_stat;
  logic              cmd_second;
  logic              addr_cmd;
  logic              pf_start;
  logic [13:0]       addr_word;
  logic [ADDR_W-1:0] addr_load;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next;
  logic [7:0]        latch;
  logic [7:0]        buffer;
  logic              frame_flag;
  ctl_state_e        ctl_state;
  logic [7:0]        reg_file [NUM_REGS];

  assign hit_data = (a == PORT_BASE);
  assign hit_ctl  = (a == (PORT_BASE | 8'h01));

  assign wr_data = wr_tick & hit_data;
  assign wr_ctl  = wr_tick & hit_ctl;
  assign rd_data = rd_tick & hit_data;
  assign rd_stat = rd_tick & hit_ctl;

  assign cmd_second = wr_ctl & (ctl_state == SECOND);
  assign addr_cmd   = cmd_second & ((d_in[7:6] == CTL_WADDR) | (d_in[7:6] == CTL_RADDR));
  assign pf_start   = (cmd_second & (d_in[7:6] == CTL_RADDR)) | rd_data;

  // Address command: six high bits from the command byte, low byte latched
  assign addr_word = {d_in[5:0], latch};
  assign addr_load = addr_word[ADDR_W-1:0];

  assign d_oe = iorq_rd & (hit_data | hit_ctl);

  // CPU read mux: read-ahead buffer on the data port, status on control
  always_comb begin
    d_out = 8'h00;
    if (hit_data) begin
      d_out = buffer;
    end else if (hit_ctl) begin
      d_out = status_byte(frame_flag);
    end
  end

  // Pointer after this cycle's access; data accesses step, commands load
  always_comb begin
    ptr_next = ptr;
    if (wr_data | rd_data) begin
      ptr_next = ptr + ADDR_W'(1);
    end else if (addr_cmd) begin
      ptr_next = addr_load;
    end
  end

  // Control protocol and register file; data/status accesses resync to FIRST
  always_ff @(negedge phi) begin
    if (reset) begin
      ctl_state <= FIRST;
      latch     <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_file[i] <= 8'h00;
      end
    end else if (wr_data | rd_data | rd_stat) begin
      ctl_state <= FIRST;
    end else if (wr_ctl) begin
      if (ctl_state == FIRST) begin
        latch     <= d_in;
        ctl_state <= SECOND;
      end else begin
        if (d_in[7:6] == CTL_REG) begin
          reg_file[d_in[IDX_W-1:0]] <= latch;
        end
        ctl_state <= FIRST;
      end
    end
  end

  // VRAM pointer and write port; vram_addr follows whichever access is issued
  always_ff @(negedge phi) begin
    if (reset) begin
      ptr        <= '0;
      vram_addr  <= '0;
      vram_wdata <= 8'h00;
      vram_we    <= 1'b0;
    end else begin
      ptr     <= ptr_next;
      vram_we <= wr_data;
      if (wr_data) begin
        vram_addr  <= ptr;
        vram_wdata <= d_in;
      end else if (pf_start) begin
        vram_addr <= ptr_next;
      end
    end
  end

  // Frame flag (set wins over a coincident status read) and registered interrupt
  always_ff @(negedge phi) begin
    if (reset) begin
      frame_flag <= 1'b0;
      int_n      <= 1'b1;
    end else begin
      if (frame_tick) begin
        frame_flag <= 1'b1;
      end else if (rd_stat) begin
        frame_flag <= 1'b0;
      end
      int_n <= ~(frame_flag & reg_file[1][REG1_IE_BIT]);
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[8*g +: 8] = reg_file[g];
  end

  vdp_prefetch u_prefetch (
    .phi    (phi),
    .reset  (reset),
    .start  (pf_start),
    .wr     (wr_data),
    .wdata  (d_in),
    .rdata  (vram_rdata),
    .buffer (buffer),
    .re     (vram_re)
  );

endmodule

// File: tb/tb_vdp_bus_if.sv
// Directed bench for vdp_bus_if: a table of CPU port operations with
// hand-computed results, plus sequences for interrupt latency, prefetch
// abort and reset during a prefetch. VRAM is a behavioural array.
module tb_vdp_bus_if;

  localparam logic [7:0] DP = 8'h80;
  localparam logic [7:0] CP = 8'h81;
  localparam int OW = 0;
  localparam int OR = 1;
  localparam int OF = 2;

  logic        phi = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  a = 8'h00;
  logic [7:0]  d_in = 8'h00;
  logic        iorq_rd = 1'b0;
  logic        rd_tick = 1'b0;
  logic        wr_tick = 1'b0;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic        vram_re;
  logic [7:0]  vram_rdata = 8'h00;
  logic        frame_tick = 1'b0;
  logic [63:0] regs;
  logic        int_n;

  logic [7:0]  mem [16384];
  int          overlap = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  typedef struct {
    int          op;
    logic [7:0]  pa;
    logic [7:0]  pd;
    logic        cd;
    logic [7:0]  dout;
    logic        cw;
    logic [13:0] waddr;
    logic [7:0]  wdata;
    logic        cr;
    logic [13:0] raddr;
    logic        cg;
    logic [63:0] eregs;
    logic        ci;
    logic        eint;
    string       name;
  } vec_t;

  vec_t tbl[$];

  vdp_bus_if dut (
    .phi        (phi),
    .reset      (reset),
    .a          (a),
    .d_in       (d_in),
    .iorq_rd    (iorq_rd),
    .rd_tick    (rd_tick),
    .wr_tick    (wr_tick),
    .d_out      (d_out),
    .d_oe       (d_oe),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .vram_re    (vram_re),
    .vram_rdata (vram_rdata),
    .frame_tick (frame_tick),
    .regs       (regs),
    .int_n      (int_n)
  );

  always #5 phi = ~phi;

  // Behavioural VRAM: samples strobes mid-cycle, read data valid the next cycle
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h0100] = 8'h3C;
    mem[14'h0101] = 8'hC3;
    forever begin
      @(posedge phi);
      if (vram_we && vram_re) overlap++;
      if (vram_we) mem[vram_addr] = vram_wdata;
      if (vram_re) vram_rdata = mem[vram_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int op, input logic [7:0] pa, input logic [7:0] pd,
                              input logic cd, input logic [7:0] dout,
                              input logic cw, input logic [13:0] waddr, input logic [7:0] wdata,
                              input logic cr, input logic [13:0] raddr,
                              input logic cg, input logic [63:0] eregs,
                              input logic ci, input logic eint, input string name);
    vec_t v;
    v.op = op; v.pa = pa; v.pd = pd; v.cd = cd; v.dout = dout;
    v.cw = cw; v.waddr = waddr; v.wdata = wdata; v.cr = cr; v.raddr = raddr;
    v.cg = cg; v.eregs = eregs; v.ci = ci; v.eint = eint; v.name = name;
    return v;
  endfunction

  // One-cycle port operation, entered and left on a rising edge
  task automatic tick(input int op, input logic [7:0] pa, input logic [7:0] pd);
    a = pa;
    d_in = pd;
    wr_tick = (op == OW);
    rd_tick = (op == OR);
    frame_tick = (op == OF);
    iorq_rd = (op == OR);
    @(posedge phi);
    wr_tick = 1'b0;
    rd_tick = 1'b0;
    frame_tick = 1'b0;
    iorq_rd = 1'b0;
  endtask

  task automatic cpu_peek(input logic [7:0] pa, output logic [8:0] oe_data);
    a = pa;
    iorq_rd = 1'b1;
    #1;
    oe_data = {d_oe, d_out};
    iorq_rd = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    logic [8:0] od;
    if (v.cd) begin
      cpu_peek(v.pa, od);
      chk({v.name, " dout"}, {55'd0, od}, {55'd0, 1'b1, v.dout});
    end
    tick(v.op, v.pa, v.pd);
    if (v.cw) chk({v.name, " write"}, {41'd0, vram_we, vram_re, vram_addr, vram_wdata},
                  {41'd0, 1'b1, 1'b0, v.waddr, v.wdata});
    if (v.cr) chk({v.name, " read"}, {48'd0, vram_re, vram_we, vram_addr},
                  {48'd0, 1'b1, 1'b0, v.raddr});
    repeat (3) @(posedge phi);
    if (v.cg) chk({v.name, " regs"}, regs, v.eregs);
    if (v.ci) chk({v.name, " int_n"}, {63'd0, int_n}, {63'd0, v.eint});
  endtask

  initial begin
    logic [8:0] od;

    //     op  port data  dout       write               read        regs                       int
    tbl.push_back(mk(OW, CP, 8'h0F, 0, 0,     0, 0, 0,          0, 0,        0, 0,                     0, 0, "ctl0f"));
    tbl.push_back(mk(OW, CP, 8'h87, 0, 0,     0, 0, 0,          0, 0,        1, 64'h0F00_0000_0000_0000, 0, 0, "reg7"));
    tbl.push_back(mk(OW, CP, 8'h00, 0, 0,     0, 0, 0,          0, 0,        0, 0,                     0, 0, "wa_lo"));
    tbl.push_back(mk(OW, CP, 8'h40, 0, 0,     0, 0, 0,          0, 0,        0, 0,                     0, 0, "wa_hi"));
    tbl.push_back(mk(OW, DP, 8'hAA, 0, 0,     1, 14'h0000, 8'hAA, 0, 0,      0, 0,                     0, 0, "wr_aa"));
    tbl.push_back(mk(OW, DP, 8'h55, 0, 0,     1, 14'h0001, 8'h55, 0, 0,      0, 0,                     0, 0, "wr_55"));
    tbl.push_back(mk(OW, DP, 8'h66, 0, 0,     1, 14'h0002, 8'h66, 0, 0,      0, 0,                     0, 0, "ptr2"));
    tbl.push_back(mk(OW, CP, 8'h00, 0, 0,     0, 0, 0,          0, 0,        0, 0,                     0, 0, "ra_lo"));
    tbl.push_back(mk(OW, CP, 8'h01, 0, 0,     0, 0, 0,          1, 14'h0100, 0, 0,                     0, 0, "pf100"));
    tbl.push_back(mk(OR, DP, 8'h00, 1, 8'h3C, 0, 0, 0,          1, 14'h0101, 0, 0,                     0, 0, "rd_3c"));
    tbl.push_back(mk(OR, DP, 8'h00, 1, 8'hC3, 0, 0, 0,          1, 14'h0102, 0, 0,                     0, 0, "rd_c3"));
    tbl.push_back(mk(OW, DP, 8'h77, 0, 0,     1, 14'h0102, 8'h77, 0, 0,      0, 0,                     0, 0, "ptr102"));
    tbl.push_back(mk(OW, CP, 8'hFF, 0, 0,     0, 0, 0,          0, 0,        0, 0,                     0, 0, "top_lo"));
    tbl.push_back(mk(OW, CP, 8'h7F, 0, 0,     0, 0, 0,          0, 0,        0, 0,                     0, 0, "top_hi"));
    tbl.push_back(mk(OW, DP, 8'h11, 0, 0,     1, 14'h3FFF, 8'h11, 0, 0,      0, 0,                     0, 0, "wr_top"));
    tbl.push_back(mk(OW, DP, 8'h22, 0, 0,     1, 14'h0000, 8'h22, 0, 0,      0, 0,                     0, 0, "wrap"));
    tbl.push_back(mk(OW, CP, 8'h20, 0, 0,     0, 0, 0,          0, 0,        0, 0,                     0, 0, "ie_val"));
    tbl.push_back(mk(OW, CP, 8'h81, 0, 0,     0, 0, 0,          0, 0,        1, 64'h0F00_0000_0000_2000, 1, 1, "reg1"));
    tbl.push_back(mk(OF, 8'h00, 8'h00, 0, 0,  0, 0, 0,          0, 0,        0, 0,                     1, 0, "irq"));
    tbl.push_back(mk(OR, CP, 8'h00, 1, 8'h80, 0, 0, 0,          0, 0,        0, 0,                     1, 1, "stat80"));
    tbl.push_back(mk(OR, CP, 8'h00, 1, 8'h00, 0, 0, 0,          0, 0,        0, 0,                     0, 0, "stat00"));
    tbl.push_back(mk(OW, CP, 8'h12, 0, 0,     0, 0, 0,          0, 0,        0, 0,                     0, 0, "half"));
    tbl.push_back(mk(OR, CP, 8'h00, 1, 8'h00, 0, 0, 0,          0, 0,        0, 0,                     0, 0, "resync"));
    tbl.push_back(mk(OW, CP, 8'h34, 0, 0,     0, 0, 0,          0, 0,        0, 0,                     0, 0, "ctl34"));
    tbl.push_back(mk(OW, CP, 8'h82, 0, 0,     0, 0, 0,          0, 0,        1, 64'h0F00_0000_0034_2000, 0, 0, "reg2"));
    tbl.push_back(mk(OW, 8'h82, 8'h87, 0, 0,  0, 0, 0,          0, 0,        0, 0,                     0, 0, "foreign"));
    tbl.push_back(mk(OW, CP, 8'h55, 0, 0,     0, 0, 0,          0, 0,        0, 0,                     0, 0, "ctl55"));
    tbl.push_back(mk(OW, CP, 8'h83, 0, 0,     0, 0, 0,          0, 0,        1, 64'h0F00_0000_5534_2000, 0, 0, "reg3"));
    tbl.push_back(mk(OW, CP, 8'h99, 0, 0,     0, 0, 0,          0, 0,        0, 0,                     0, 0, "ctl99"));
    tbl.push_back(mk(OW, CP, 8'h8C, 0, 0,     0, 0, 0,          0, 0,        1, 64'h0F00_0099_5534_2000, 0, 0, "idx_hi"));

    repeat (3) @(posedge phi);
    reset = 1'b0;
    @(posedge phi);

    chk("rst regs", regs, 64'd0);
    chk("rst int_n", {63'd0, int_n}, 64'd1);
    chk("rst strobes", {62'd0, vram_we, vram_re}, 64'd0);
    chk("rst vram_addr", {50'd0, vram_addr}, 64'd0);
    a = DP;
    #1;
    chk("rst d_oe idle", {63'd0, d_oe}, 64'd0);
    cpu_peek(DP, od);
    chk("rst data read", {55'd0, od}, {55'd0, 9'h100});
    cpu_peek(8'h82, od);
    chk("off-window d_oe", {63'd0, od[8]}, 64'd0);
    @(posedge phi);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Interrupt latency, then a status read colliding with a new frame
    tick(OF, 8'h00, 8'h00);
    chk("int_n latency", {63'd0, int_n}, 64'd1);
    @(posedge phi);
    chk("int_n asserted", {63'd0, int_n}, 64'd0);
    a = CP;
    iorq_rd = 1'b1;
    rd_tick = 1'b1;
    frame_tick = 1'b1;
    @(posedge phi);
    rd_tick = 1'b0;
    frame_tick = 1'b0;
    iorq_rd = 1'b0;
    repeat (2) @(posedge phi);
    chk("collide int_n", {63'd0, int_n}, 64'd0);
    cpu_peek(CP, od);
    chk("collide flag", {55'd0, od}, {55'd0, 9'h180});
    @(posedge phi);
    tick(OR, CP, 8'h00);
    repeat (2) @(posedge phi);
    chk("cleared int_n", {63'd0, int_n}, 64'd1);

    // Data write while the prefetch is in FETCH
    tick(OW, CP, 8'h00);
    tick(OW, CP, 8'h01);
    chk("fetch strobe", {48'd0, vram_re, vram_we, vram_addr}, {48'd0, 2'b10, 14'h0100});
    tick(OW, DP, 8'h5A);
    chk("abort fetch wr", {41'd0, vram_we, vram_re, vram_addr, vram_wdata},
        {41'd0, 2'b10, 14'h0100, 8'h5A});
    repeat (3) @(posedge phi);
    cpu_peek(DP, od);
    chk("abort fetch buf", {55'd0, od}, {55'd0, 9'h15A});
    @(posedge phi);

    // Data write while the prefetch is in LATCH
    tick(OW, CP, 8'h01);
    tick(OW, CP, 8'h01);
    @(posedge phi);
    tick(OW, DP, 8'h6B);
    chk("abort latch wr", {41'd0, vram_we, vram_re, vram_addr, vram_wdata},
        {41'd0, 2'b10, 14'h0101, 8'h6B});
    repeat (3) @(posedge phi);
    cpu_peek(DP, od);
    chk("abort latch buf", {55'd0, od}, {55'd0, 9'h16B});
    @(posedge phi);

    // Reset landing on a prefetch in flight
    tick(OW, CP, 8'h00);
    tick(OW, CP, 8'h01);
    reset = 1'b1;
    @(posedge phi);
    reset = 1'b0;
    repeat (3) @(posedge phi);
    cpu_peek(DP, od);
    chk("reset pf buf", {55'd0, od}, {55'd0, 9'h100});
    chk("reset pf regs", regs, 64'd0);
    chk("reset pf int_n", {63'd0, int_n}, 64'd1);
    @(posedge phi);

    chk("we/re overlap", 64'(overlap), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
